// File: rtl/wb_stage_regfile_if.sv
// MEM/WB-to-writeback bundle plus the decode read ports
// of the integer register file.
interface wb_stage_regfile_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            mem_wb_MemtoReg;
    logic            mem_wb_RegWrite;
    logic [AW-1:0]   mem_wb_rd;
    logic [XLEN-1:0] mem_wb_alu_result;
    logic [XLEN-1:0] mem_wb_mem_data;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            wb_RegWrite;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_registerout;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    modport master (
        output mem_wb_MemtoReg,
        output mem_wb_RegWrite,
        output mem_wb_rd,
        output mem_wb_alu_result,
        output mem_wb_mem_data,
        output rs1_addr,
        output rs2_addr,
        input  wb_RegWrite,
        input  wb_rd,
        input  wb_registerout,
        input  rs1_data,
        input  rs2_data
    );

    modport slave (
        input  mem_wb_MemtoReg,
        input  mem_wb_RegWrite,
        input  mem_wb_rd,
        input  mem_wb_alu_result,
        input  mem_wb_mem_data,
        input  rs1_addr,
        input  rs2_addr,
        output wb_RegWrite,
        output wb_rd,
        output wb_registerout,
        output rs1_data,
        output rs2_data
    );
endinterface

// File: rtl/wb_stage_regfile.sv
// Writeback stage: result select, forwarding controls and
// the 32 x XLEN integer register file with write-first bypass.
module wb_stage_regfile #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic clk,
    input  logic reset,
    wb_stage_regfile_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] sel;
    logic            we;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    assign sel = bus.mem_wb_MemtoReg ? bus.mem_wb_mem_data
                                     : bus.mem_wb_alu_result;
    assign we  = bus.mem_wb_RegWrite && (bus.mem_wb_rd != '0);

    assign bus.wb_registerout = sel;
    assign bus.wb_rd          = bus.mem_wb_rd;
    assign bus.wb_RegWrite    = we;
    assign bus.rs1_data       = rd1;
    assign bus.rs2_data       = rd2;

    // Array update; reset wins over any write, x0 is never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[bus.mem_wb_rd] <= sel;
        end
    end

    // Read ports: x0 and reset read zero, same-cycle write is bypassed.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (!reset && bus.rs1_addr != '0) begin
            if (we && bus.mem_wb_rd == bus.rs1_addr) begin
                rd1 = sel;
            end else begin
                rd1 = regs[bus.rs1_addr];
            end
        end
        if (!reset && bus.rs2_addr != '0) begin
            if (we && bus.mem_wb_rd == bus.rs2_addr) begin
                rd2 = sel;
            end else begin
                rd2 = regs[bus.rs2_addr];
            end
        end
    end

    logic [AW-1:0] unused_aw;
    assign unused_aw = '0;
endmodule

// File: tb/tb_wb_stage_regfile.sv
// Self-checking bench for wb_stage_regfile against an
// architectural register-file model.
module tb_wb_stage_regfile;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [63:0] model [32];

    wb_stage_regfile_if #(.XLEN(64), .AW(5)) bus ();

    wb_stage_regfile #(.XLEN(64), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic we, input logic m2r,
                         input logic [4:0] rd,
                         input logic [63:0] alu,
                         input logic [63:0] mem,
                         input logic [4:0] a1,
                         input logic [4:0] a2);
        bus.mem_wb_RegWrite   = we;
        bus.mem_wb_MemtoReg   = m2r;
        bus.mem_wb_rd         = rd;
        bus.mem_wb_alu_result = alu;
        bus.mem_wb_mem_data   = mem;
        bus.rs1_addr          = a1;
        bus.rs2_addr          = a2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] sel_val();
        return bus.mem_wb_MemtoReg ? bus.mem_wb_mem_data
                                   : bus.mem_wb_alu_result;
    endfunction

    function automatic logic commits();
        return !reset && bus.mem_wb_RegWrite === 1'b1
               && bus.mem_wb_rd != 5'd0;
    endfunction

    // What decode should see for a register this cycle.
    function automatic logic [63:0] visible(input logic [4:0] a);
        if (reset || a == 5'd0) return 64'd0;
        if (commits() && bus.mem_wb_rd == a) return sel_val();
        return model[a];
    endfunction

    task automatic commit_edge();
        logic do_w;
        logic [4:0] rd;
        logic [63:0] v;
        do_w = commits();
        rd = bus.mem_wb_rd;
        v = sel_val();
        tick();
        if (do_w) model[rd] = v;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        drive(1'b0, 1'b0, 5'd0, 64'd100, 64'd200, 5'd5, 5'd31);
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.rs1_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_rs1 got %h want 0", bus.rs1_data);
        end
        n_checks++;
        if (bus.rs2_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_rs2 got %h want 0", bus.rs2_data);
        end
        n_checks++;
        if (bus.wb_registerout !== 64'd100) begin
            n_fail++;
            $display("FAIL reset_sel got %h want 100",
                     bus.wb_registerout);
        end
        n_checks++;
        if (bus.wb_RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_we got %b want 0", bus.wb_RegWrite);
        end
        tick();
    endtask

    task automatic test_alu_wb();
        drive(1'b1, 1'b0, 5'd10, 64'd100, 64'd0, 5'd10, 5'd0);
        n_checks++;
        if (bus.wb_registerout !== 64'd100 || bus.wb_rd !== 5'd10
            || bus.wb_RegWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_ctrl got %h/%0d/%b want 100/10/1",
                     bus.wb_registerout, bus.wb_rd, bus.wb_RegWrite);
        end
        n_checks++;
        if (bus.rs1_data !== 64'd100) begin
            n_fail++;
            $display("FAIL alu_bypass got %h want 100", bus.rs1_data);
        end
        commit_edge();
        drive(1'b0, 1'b0, 5'd10, 64'd1, 64'd2, 5'd10, 5'd0);
        n_checks++;
        if (bus.rs1_data !== 64'd100) begin
            n_fail++;
            $display("FAIL alu_array got %h want 100", bus.rs1_data);
        end
    endtask

    task automatic test_load_wb();
        drive(1'b1, 1'b1, 5'd15, 64'd9, 64'd200, 5'd10, 5'd0);
        n_checks++;
        if (bus.wb_registerout !== 64'd200) begin
            n_fail++;
            $display("FAIL load_sel got %h want 200",
                     bus.wb_registerout);
        end
        commit_edge();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd10, 5'd15);
        n_checks++;
        if (bus.rs2_data !== 64'd200 || bus.rs1_data !== 64'd100) begin
            n_fail++;
            $display("FAIL load_array got %h/%h want 200/100",
                     bus.rs2_data, bus.rs1_data);
        end
    endtask

    task automatic test_write_disabled();
        drive(1'b0, 1'b1, 5'd15, 64'd0, 64'd300, 5'd15, 5'd15);
        n_checks++;
        if (bus.wb_registerout !== 64'd300 || bus.wb_RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL nowr_ctrl got %h/%b want 300/0",
                     bus.wb_registerout, bus.wb_RegWrite);
        end
        n_checks++;
        if (bus.rs1_data !== 64'd200) begin
            n_fail++;
            $display("FAIL nowr_nobypass got %h want 200", bus.rs1_data);
        end
        commit_edge();
        n_checks++;
        if (bus.rs2_data !== 64'd200) begin
            n_fail++;
            $display("FAIL nowr_array got %h want 200", bus.rs2_data);
        end
    endtask

    task automatic test_x0();
        drive(1'b1, 1'b0, 5'd0, 64'hDEADBEEF, 64'd0, 5'd0, 5'd0);
        n_checks++;
        if (bus.wb_RegWrite !== 1'b0 || bus.rs1_data !== 64'd0
            || bus.rs2_data !== 64'd0) begin
            n_fail++;
            $display("FAIL x0_before got %b/%h want 0/0",
                     bus.wb_RegWrite, bus.rs1_data);
        end
        commit_edge();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd0, 5'd0);
        n_checks++;
        if (bus.rs1_data !== 64'd0) begin
            n_fail++;
            $display("FAIL x0_after got %h want 0", bus.rs1_data);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd10, 5'd15);
        #3;
        reset = 1'b1;
        #0.5;
        n_checks++;
        if (bus.rs1_data !== 64'd0 || bus.rs2_data !== 64'd0) begin
            n_fail++;
            $display("FAIL areset_immediate got %h/%h want 0/0",
                     bus.rs1_data, bus.rs2_data);
        end
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        drive(1'b1, 1'b0, 5'd10, 64'd55, 64'd0, 5'd10, 5'd15);
        commit_edge();
        bus.mem_wb_RegWrite = 1'bx;
        commit_edge();
        drive(1'b0, 1'b0, 5'd3, 64'd7, 64'd0, 5'd10, 5'd3);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.rs1_data !== 64'd0) begin
            n_fail++;
            $display("FAIL areset_ignored got %h want 0", bus.rs1_data);
        end
        tick();
        drive(1'b1, 1'b0, 5'd3, 64'd7, 64'd0, 5'd10, 5'd3);
        commit_edge();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd10, 5'd3);
        n_checks++;
        if (bus.rs2_data !== 64'd7 || bus.rs1_data !== 64'd0) begin
            n_fail++;
            $display("FAIL areset_after got %h/%h want 7/0",
                     bus.rs2_data, bus.rs1_data);
        end
    endtask

    task automatic test_random();
        logic [4:0] rd;
        logic [4:0] a1;
        logic [4:0] a2;
        logic [63:0] e;
        for (int n = 0; n < 300; n++) begin
            rd = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            drive(1'($urandom), 1'($urandom), rd,
                  {$urandom, $urandom}, {$urandom, $urandom}, a1, a2);
            e = sel_val();
            n_checks++;
            if (bus.wb_registerout !== e || bus.wb_rd !== rd
                || bus.wb_RegWrite !== commits()) begin
                n_fail++;
                $display("FAIL rnd_ctrl[%0d] got %h/%0d/%b want %h/%0d/%b",
                         n, bus.wb_registerout, bus.wb_rd,
                         bus.wb_RegWrite, e, rd, commits());
            end
            n_checks++;
            if (bus.rs1_data !== visible(a1)) begin
                n_fail++;
                $display("FAIL rnd_rs1[%0d] x%0d got %h want %h",
                         n, a1, bus.rs1_data, visible(a1));
            end
            n_checks++;
            if (bus.rs2_data !== visible(a2)) begin
                n_fail++;
                $display("FAIL rnd_rs2[%0d] x%0d got %h want %h",
                         n, a2, bus.rs2_data, visible(a2));
            end
            commit_edge();
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 5'd0, 5'd0);
        test_reset();
        test_alu_wb();
        test_load_wb();
        test_write_disabled();
        test_x0();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_stage_regfile.md
Name: wb_stage_regfile

Overview:
- Writeback stage of the 5-stage pipelined RV64 core, fed by the MEM/WB pipeline register.
- Selects the result to write back, either the ALU result or load data, and presents the write control to forwarding logic.
- Owns the integer register file: 32 x 64-bit, two read ports used by decode, write-first bypass.
- Single clock domain; asynchronous active-high reset.

Parameters:
- XLEN, 64, datapath and register width.
- NREGS, 32, number of architectural registers; address width is 5.

Ports:
- clk  input  1  clock; the register file writes on the rising edge.
- reset  input  1  asynchronous, active-high; clears the register file.
- mem_wb_MemtoReg  input  1  1 = write back mem data, 0 = write back ALU result.
- mem_wb_RegWrite  input  1  write enable from MEM/WB.
- mem_wb_rd  input  5  destination register index.
- mem_wb_alu_result  input  XLEN  ALU result from MEM/WB.
- mem_wb_mem_data  input  XLEN  load data from MEM/WB.
- rs1_addr  input  5  decode read port 1 address.
- rs2_addr  input  5  decode read port 2 address.
- wb_RegWrite  output  1  effective write enable, to forwarding logic.
- wb_rd  output  5  destination index, to forwarding logic.
- wb_registerout  output  XLEN  selected writeback value.
- rs1_data  output  XLEN  read port 1 data.
- rs2_data  output  XLEN  read port 2 data.

Behaviour:
- wb_registerout is combinational: mem_wb_mem_data when mem_wb_MemtoReg=1, otherwise mem_wb_alu_result. It is independent of mem_wb_RegWrite and of reset.
- wb_rd = mem_wb_rd, combinational pass-through.
- wb_RegWrite = mem_wb_RegWrite AND (mem_wb_rd != 0), combinational. x0 never appears as a forwarding source.
- Register write: on rising clk, when wb_RegWrite=1 and reset=0, regs[wb_rd] <= wb_registerout.
- Writes to x0 are discarded. x0 always reads 0.
- Reset: asserting reset asynchronously clears all registers to 0, and rs1_data/rs2_data become 0 within the same delta.
  - Reset has priority over a coincident write edge.
  - Deassertion takes effect at the next edge.
- Reads are combinational: rsN_data = regs[rsN_addr].
- Write-first bypass: if wb_RegWrite=1, wb_rd == rsN_addr and rsN_addr != 0, then rsN_data = wb_registerout in the same cycle, before the edge. This resolves the WB-to-ID hazard without an extra stall.
- Both read ports may address the same register; both return identical data, including the bypass case.
- Inputs are not registered. Writeback latency from MEM/WB to visibility:
  - 0 cycles on the bypass path.
  - 1 edge in the array.
- X on mem_wb_RegWrite must not corrupt the array while reset=1.
- No state machine; the only state is the register array.

Test Plan:
- Reset, then rs1_addr=5, rs2_addr=31 -> rs1_data=0, rs2_data=0. With RegWrite=0, MemtoReg=0, alu=100, mem=200 -> wb_registerout=100, wb_RegWrite=0.
- ALU writeback: RegWrite=1, MemtoReg=0, rd=10, alu=100, rs1_addr=10 -> wb_registerout=100, wb_rd=10, wb_RegWrite=1, rs1_data=100 before the edge (bypass). After the edge, with RegWrite=0, rs1_data=100.
- Load writeback: RegWrite=1, MemtoReg=1, rd=15, mem=200 -> wb_registerout=200. After the edge, with rs2_addr=15, rs2_data=200 and x10 still reads 100.
- Write disabled: RegWrite=0, MemtoReg=1, rd=15, mem=300 -> wb_registerout=300, wb_RegWrite=0. After the edge, x15 still reads 200.
- x0 protection: RegWrite=1, rd=0, alu=0xDEADBEEF -> wb_RegWrite=0. rs1_addr=0 reads 0 both before and after the edge.
- Async reset mid-operation: with x10=100, assert reset between edges -> rs1_data(x10)=0 immediately. A write with RegWrite=1 during reset is ignored. After deassertion, a normal write of 7 to x3 succeeds on the next edge.
